// File: rtl/dm_arbiter.sv
// dm_arbiter: round-robin arbiter sharing one data memory between two masters,
// one checked access (IDLE -> ACC -> RESP) every three cycles.
module dm_arbiter #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_ls,
    output logic        m0_gnt,
    output logic        m0_rvalid,
    output logic [31:0] m0_rdata,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_ls,
    output logic        m1_gnt,
    output logic        m1_rvalid,
    output logic [31:0] m1_rdata,
    output logic        m1_err,
    output logic        dm_wr,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_din,
    output logic [3:0]  dm_ls,
    input  logic [31:0] dm_dout
);
    typedef enum logic [1:0] {IDLE, ACC, RESP} state_t;
    state_t state, state_nx;
    logic win, last, l_we, l_err, sel, sel_we, sel_err, legal, acc;
    logic [31:0] l_addr, l_wdata, sel_addr, sel_wdata, rd;
    logic [3:0] l_ls, sel_ls;
    logic [2:0] size;
    logic [32:0] end_addr;

    always_comb begin
        state_nx = IDLE;
        case (state)
            IDLE:    state_nx = (m0_req || m1_req) ? ACC : IDLE;
            ACC:     state_nx = RESP;
            default: state_nx = IDLE;
        endcase
    end

    // A lone requester always wins; a tie goes to whoever was not granted last.
    assign sel       = (m0_req && m1_req) ? ~last : m1_req;
    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;
    assign sel_ls    = sel ? m1_ls    : m0_ls;

    assign legal = sel_ls inside {4'b0000, 4'b1000, 4'b0100, 4'b0010, 4'b0001};
    assign size = (sel_ls == 4'b0000) ? 3'd4 : (sel_ls == 4'b1000 || sel_ls == 4'b0010) ? 3'd2 : 3'd1;
    assign end_addr = {1'b0, sel_addr} + 33'(size);
    assign sel_err = !legal
                  || (sel_we && (sel_ls == 4'b0010 || sel_ls == 4'b0001))
                  || (sel_ls == 4'b0000 && sel_addr[1:0] != 2'b00)
                  || ((sel_ls == 4'b1000 || sel_ls == 4'b0010) && sel_addr[0])
                  || end_addr > 33'(MEM_BYTES);

    assign rd = (!l_we && !l_err) ? dm_dout : '0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            win      <= 1'b0;
            last     <= 1'b1;
            l_we     <= 1'b0;
            l_err    <= 1'b0;
            l_addr   <= '0;
            l_wdata  <= '0;
            l_ls     <= '0;
            m0_rdata <= '0;
            m0_err   <= 1'b0;
            m1_rdata <= '0;
            m1_err   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && state_nx == ACC) begin
                win     <= sel;
                last    <= sel;
                l_we    <= sel_we;
                l_err   <= sel_err;
                l_addr  <= sel_addr;
                l_wdata <= sel_wdata;
                l_ls    <= sel_ls;
            end
            if (state == ACC && !win) begin
                m0_rdata <= rd;
                m0_err   <= l_err;
            end
            if (state == ACC && win) begin
                m1_rdata <= rd;
                m1_err   <= l_err;
            end
        end
    end

    assign acc       = state == ACC;
    assign m0_gnt    = acc && !win;
    assign m1_gnt    = acc && win;
    assign m0_rvalid = state == RESP && !win;
    assign m1_rvalid = state == RESP && win;
    assign dm_wr     = acc && l_we && !l_err;
    assign dm_addr   = acc ? l_addr  : '0;
    assign dm_din    = acc ? l_wdata : '0;
    assign dm_ls     = acc ? l_ls    : '0;
endmodule

// File: doc/dm_arbiter.md
DM_ARBITER -- requirements
Module: dm_arbiter

Interface
REQ-001 Parameter MEM_BYTES, default 1024, number of valid data-memory byte addresses (0..MEM_BYTES-1).
REQ-002 clk  input  1  single clock, all state on rising edge.
REQ-003 rstn  input  1  asynchronous, active-low reset.
REQ-004 m0_req / m1_req  input  1  access request from master 0 (CPU LSU) / master 1 (debug/DMA).
REQ-005 m0_we / m1_we  input  1  1 = store, 0 = load.
REQ-006 m0_addr / m1_addr  input  32  byte address.
REQ-007 m0_wdata / m1_wdata  input  32  store data, LSB-aligned.
REQ-008 m0_ls / m1_ls  input  4  size code: 0000 w, 1000 h, 0100 b, 0010 hu, 0001 bu.
REQ-009 m0_gnt / m1_gnt  output  1  one-cycle pulse: request accepted, inputs may change.
REQ-010 m0_rvalid / m1_rvalid  output  1  one-cycle completion pulse (loads and stores).
REQ-011 m0_rdata / m1_rdata  output  32  load result, valid with rvalid.
REQ-012 m0_err / m1_err  output  1  access rejected, valid with rvalid.
REQ-013 dm_wr  output  1  write enable to data memory.
REQ-014 dm_addr  output  32  byte address to data memory.
REQ-015 dm_din  output  32  write data to data memory.
REQ-016 dm_ls  output  4  size code to data memory.
REQ-017 dm_dout  input  32  read data from data memory, valid by end of the access cycle (memory reads on falling edge).

Function
REQ-018 FSM states IDLE, ACC, RESP; IDLE->ACC when any req sampled high; ACC->RESP unconditionally; RESP->IDLE unconditionally; one access per 3 cycles.
REQ-019 req sampled only in IDLE; req high in ACC/RESP is ignored until next IDLE.
REQ-020 Both req high in IDLE: grant master not granted last (round-robin); single req: grant it regardless of pointer.
REQ-021 On IDLE->ACC edge: latch winner id, we, addr, wdata, ls, error flag; update round-robin pointer to winner.
REQ-022 In ACC: winner gnt=1 for exactly that cycle; dm_addr/dm_din/dm_ls driven from latched values; dm_wr=1 iff latched we=1 and no error.
REQ-023 Outside ACC: dm_wr=0, dm_addr=0, dm_din=0, dm_ls=0000.
REQ-024 On ACC->RESP edge: rdata register = dm_dout for error-free loads, else 0; err register = latched error flag.
REQ-025 In RESP: winner rvalid=1 for exactly one cycle with rdata/err; other master rvalid=0, gnt=0.
REQ-026 rdata and err hold their value until next RESP of the same master; never change on the other master's response.
REQ-027 Error = any of: ls not one of the five legal codes; store with ls 0010 or 0001; ls 0000 with addr[1:0]!=0; ls 1000/0010 with addr[0]!=0; addr+size > MEM_BYTES (size 4/2/1, computed in 33 bits, no wrap).
REQ-028 Erroneous access: full ACC/RESP sequence still executes, no memory write, rdata=0, err=1.
REQ-029 Latency: req high in IDLE cycle T -> gnt in T+1 -> rvalid in T+2 -> next grant earliest T+4.

Reset
REQ-030 rstn low: immediately state=IDLE, all outputs 0 (dm_ls=0000), rdata/err registers 0, round-robin pointer = master 1 last granted (master 0 wins first tie).
REQ-031 rstn asserted during ACC: dm_wr drops asynchronously; aborted access produces no rvalid after reset release.
REQ-032 First sampling after rstn deasserts occurs on the first rising edge with rstn high.

Verification
REQ-033 m0 store w addr 0x10 data 0xDEADBEEF, then m0 load w 0x10 -> dm_wr=1 only in store ACC cycle; load rvalid with rdata 0xDEADBEEF, err 0.
REQ-034 m0 and m1 req together twice back-to-back -> grants m0, m1, m0, m1 in order; each rvalid 1 cycle after its gnt.
REQ-035 m1 load h addr 0x21 -> dm_wr 0, m1_rvalid 1, m1_err 1, m1_rdata 0; m0 outputs unchanged.
REQ-036 m0 load w addr 0x3FC ok; load w 0x3FD and store b 0x400 -> err 1, no memory write.
REQ-037 Store byte 0x80 to 0x5, load b 0x5 -> 0xFFFFFF80; load bu 0x5 -> 0x00000080.
REQ-038 rstn low during store ACC -> dm_wr 0 same cycle, no rvalid afterwards, memory location unchanged; next tie grants m0.
